// File: rtl/pe_packet_decoder_pkg.sv
// Purpose : shared definitions for the PE packet decoder and the downstream split stage.
// Latency : n/a (types, constants and helper functions only).
// Backpressure: n/a.
//
// Contents: state encoding, default payload width / flit count, header field
// positions and small helpers that size the datapath from the element width.
package pe_packet_decoder_pkg;

    // A payload always carries five elements: one filter row or one ifmap window.
    localparam int ROWS             = 5;
    localparam int FILTER_WIDTH_DEF = 8;
    localparam int FLIT_WIDTH_DEF   = 32;
    localparam int PAYLOAD_W        = ROWS * FILTER_WIDTH_DEF;
    localparam int NPAY             = (PAYLOAD_W + FLIT_WIDTH_DEF - 1) / FLIT_WIDTH_DEF;

    // Header field positions, counted down from the flit MSB
    // (offset 0 is bit FLIT_WIDTH-1).
    localparam int HDR_TYPE_OFS   = 0;
    localparam int HDR_ROW_HI_OFS = 1;
    localparam int HDR_ROW_LO_OFS = 3;
    localparam int ROW_W          = HDR_ROW_LO_OFS - HDR_ROW_HI_OFS + 1;

    // Legal filter row tags.
    localparam logic [ROW_W-1:0] ROW_MIN = 3'd1;
    localparam logic [ROW_W-1:0] ROW_MAX = 3'd5;

    localparam int DROP_CNT_W = 8;

    // Decoder state encoding.
    typedef logic [1:0] state_t;
    localparam state_t ST_HDR = 2'd0;
    localparam state_t ST_PAY = 2'd1;
    localparam state_t ST_OUT = 2'd2;

    function automatic int calc_payload_w(input int filter_w);
        return ROWS * filter_w;
    endfunction

    // Number of payload flits: ceil(payload bits / flit bits).
    function automatic int calc_npay(input int filter_w, input int flit_w);
        return (ROWS * filter_w + flit_w - 1) / flit_w;
    endfunction

    function automatic logic row_is_valid(input logic [ROW_W-1:0] row);
        return (row >= ROW_MIN) && (row <= ROW_MAX);
    endfunction

endpackage

// File: rtl/pe_packet_decoder_sat_counter.sv
// Purpose : saturating up-counter, used for the dropped-packet statistic.
// Latency : count reflects an increment on the clock edge that samples i_inc.
// Backpressure: none; holds at all-ones instead of wrapping.
//
// Ports: clk, rst_n (async active-low), i_inc (count one event), o_cnt (current count).
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pe_packet_decoder.sv
// Purpose : reassembles header + payload flits into one (payload, type, row) triple per packet.
// Latency : out_valid rises the cycle after the last payload flit is accepted; NPAY+2 cycles/packet.
// Backpressure: in_ready drops while a triple waits in OUT; outputs hold until out_ready.
//
// Ports:
//   clk, rst_n                 single clock, async active-low reset
//   in_flit/in_valid/in_ready  flit input (header flit followed by NPAY payload flits)
//   out_data/out_ifmapb_filter/out_filter_row/out_valid/out_ready  reassembled triple
//   err_pulse                  one-cycle pulse when a filter packet with a bad row is dropped
//   drop_cnt                   saturating count of dropped packets
module pe_packet_decoder
    import pe_packet_decoder_pkg::*;
#(
    parameter int FILTER_WIDTH = 8,
    parameter int FLIT_WIDTH   = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [FLIT_WIDTH-1:0]     in_flit,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [5*FILTER_WIDTH-1:0] out_data,
    output logic                      out_ifmapb_filter,
    output logic [2:0]                out_filter_row,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      err_pulse,
    output logic [7:0]                drop_cnt
);

    localparam int PW     = calc_payload_w(FILTER_WIDTH);
    localparam int NP     = calc_npay(FILTER_WIDTH, FLIT_WIDTH);
    // The last flit only contributes its low LAST_W bits; its upper bits are padding.
    localparam int LAST_W = PW - (NP - 1) * FLIT_WIDTH;
    localparam int CNT_W  = (NP > 1) ? $clog2(NP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NP - 1);

    localparam int TYPE_BIT = FLIT_WIDTH - 1 - HDR_TYPE_OFS;
    localparam int ROW_HI   = FLIT_WIDTH - 1 - HDR_ROW_HI_OFS;
    localparam int ROW_LO   = FLIT_WIDTH - 1 - HDR_ROW_LO_OFS;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_started;
    logic [PW-1:0]    r_data;
    logic             r_type;
    logic [ROW_W-1:0] r_row;
    logic             r_err;

    logic w_acc_hdr;
    logic w_acc_pay;
    logic w_last;
    logic w_drop;
    logic w_drop_now;

    // r_started keeps in_ready low during reset and releases it on the first
    // clock edge afterwards, independent of the state register.
    assign in_ready  = r_started && (r_state != ST_OUT);

    assign w_acc_hdr  = in_valid && in_ready && (r_state == ST_HDR);
    assign w_acc_pay  = in_valid && in_ready && (r_state == ST_PAY);
    assign w_last     = w_acc_pay && (r_cnt == CNT_LAST);
    // Only filter packets are range-checked; ifmap rows pass through as-is.
    assign w_drop     = r_type && !row_is_valid(r_row);
    assign w_drop_now = w_last && w_drop;

    // ------------------------------------------------------------------
    // Control: state, payload flit counter, error pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_HDR;
            r_cnt     <= '0;
            r_started <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_started <= 1'b1;
            r_err     <= 1'b0;
            case (r_state)
                ST_HDR: begin
                    if (w_acc_hdr) begin
                        r_cnt   <= '0;
                        r_state <= ST_PAY;
                    end
                end
                ST_PAY: begin
                    if (w_acc_pay) begin
                        if (w_last) begin
                            r_cnt <= '0;
                            if (w_drop) begin
                                r_state <= ST_HDR;
                                r_err   <= 1'b1;
                            end else begin
                                r_state <= ST_OUT;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        r_state <= ST_HDR;
                    end
                end
                default: begin
                    r_state <= ST_HDR;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath: header fields and payload written straight into the output
    // registers. Nothing is accepted in OUT, so they are stable there.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_type <= 1'b0;
            r_row  <= '0;
        end else begin
            if (w_acc_hdr) begin
                r_type <= in_flit[TYPE_BIT];
                r_row  <= in_flit[ROW_HI:ROW_LO];
            end
            if (w_acc_pay) begin
                // Full flits fill the payload from the MSB downward.
                for (int k = 0; k < NP - 1; k++) begin
                    if (r_cnt == CNT_W'(k)) begin
                        r_data[PW-1-k*FLIT_WIDTH -: FLIT_WIDTH] <= in_flit;
                    end
                end
                if (w_last) begin
                    r_data[LAST_W-1:0] <= in_flit[LAST_W-1:0];
                end
            end
        end
    end

    sat_counter #(
        .WIDTH (DROP_CNT_W)
    ) u_drop_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_drop_now),
        .o_cnt (drop_cnt)
    );

    assign out_data          = r_data;
    assign out_ifmapb_filter = r_type;
    assign out_filter_row    = r_row;
    assign out_valid         = (r_state == ST_OUT);
    assign err_pulse         = r_err;

endmodule

// File: tb/tb_pe_packet_decoder.sv
`timescale 1ns/1ps
module tb_pe_packet_decoder;

    localparam int FW     = 8;
    localparam int FLW    = 32;
    localparam int PW     = 5 * FW;
    localparam int NP     = (PW + FLW - 1) / FLW;
    localparam int LAST_W = PW - (NP - 1) * FLW;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [FLW-1:0] in_flit = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [PW-1:0]  out_data;
    logic           out_ifmapb_filter;
    logic [2:0]     out_filter_row;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic           err_pulse;
    logic [7:0]     drop_cnt;

    pe_packet_decoder #(
        .FILTER_WIDTH (FW),
        .FLIT_WIDTH   (FLW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_flit           (in_flit),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .out_data          (out_data),
        .out_ifmapb_filter (out_ifmapb_filter),
        .out_filter_row    (out_filter_row),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .err_pulse         (err_pulse),
        .drop_cnt          (drop_cnt)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct packed {
        logic [PW-1:0] data;
        logic          typ;
        logic [2:0]    row;
    } exp_t;

    exp_t exp_q[$];        // expected output triples, in order
    int   err_q[$];        // expected drop_cnt value at each err_pulse
    int   tests = 0;
    int   fails = 0;
    int   model_drops = 0; // dropped packets since last reset
    bit   ordy_rand = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference model: a filter packet whose row is not 1..5 is dropped,
    // everything else comes out unchanged.
    task automatic expect_pkt(input logic typ, input logic [2:0] row, input logic [PW-1:0] p);
        exp_t e;
        if (typ && (row < 3'd1 || row > 3'd5)) begin
            model_drops++;
            err_q.push_back(model_drops > 255 ? 255 : model_drops);
        end else begin
            e.data = p;
            e.typ  = typ;
            e.row  = row;
            exp_q.push_back(e);
        end
    endtask

    function automatic logic [FLW-1:0] mk_hdr(input logic typ, input logic [2:0] row);
        logic [FLW-1:0] f;
        f = $urandom;
        f[FLW-1] = typ;
        f[FLW-2 -: 3] = row;
        return f;
    endfunction

    function automatic logic [FLW-1:0] mk_pay(input logic [PW-1:0] p, input int k);
        logic [FLW-1:0] f;
        if (k < NP - 1) begin
            f = p[PW-1-k*FLW -: FLW];
        end else begin
            f = $urandom;
            f[LAST_W-1:0] = p[LAST_W-1:0];
        end
        return f;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the flit was taken.
    task automatic send_flit(input logic [FLW-1:0] f, output int acc);
        int n;
        in_flit  = f;
        in_valid = 1'b1;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (n == 200) begin
            tests++;
            fails++;
            $display("FAIL in_ready_timeout: in_ready stayed 0 for 200 cycles, expected 1");
        end
        @(posedge clk);
        #1;
        acc = cycle;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_pkt(input logic typ, input logic [2:0] row, input logic [PW-1:0] p,
                            input int max_gap, output int hdr_acc);
        int a;
        expect_pkt(typ, row, p);
        send_flit(mk_hdr(typ, row), hdr_acc);
        for (int k = 0; k < NP; k++) begin
            if (max_gap > 0) idle($urandom_range(0, max_gap));
            send_flit(mk_pay(p, k), a);
        end
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        model_drops = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_err_pulse", err_pulse, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_type", out_ifmapb_filter, 0);
        check("rst_out_row", out_filter_row, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready_before_edge", in_ready, 0);
        @(posedge clk);
        #1;
        check("rst_in_ready_after_edge", in_ready, 1);
    endtask

    function automatic logic [PW-1:0] rand_payload();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[PW-1:0];
    endfunction

    // Random downstream backpressure.
    initial forever begin
        @(posedge clk);
        #1;
        if (ordy_rand) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Scoreboard monitor: compares on every output handshake and error pulse.
    initial forever begin
        exp_t e;
        int   ed;
        @(negedge clk);
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: data 0x%0h row %0d, expected no output", out_data, out_filter_row);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_out_data", out_data, e.data);
                    check("sb_out_type", out_ifmapb_filter, e.typ);
                    check("sb_out_row", out_filter_row, e.row);
                end
            end
            if (err_pulse) begin
                if (err_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_err_pulse: err_pulse 1, expected 0");
                end else begin
                    ed = err_q.pop_front();
                    check("sb_drop_cnt", drop_cnt, ed);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int a, hs, h0, h1, h2;
        logic [FLW-1:0] hdr;
        logic [PW-1:0]  p;
        logic [2:0]     row;
        logic           typ;

        #1;
        do_reset();

        // Filter packet; header 0xA000_0000 carries type 1 and row field 3'b010.
        hdr = 32'hA000_0000;
        expect_pkt(hdr[31], hdr[30:28], 40'h11_2233_4455);
        send_flit(hdr, a);
        send_flit(32'h1122_3344, a);
        check("f_valid_early", out_valid, 0);
        send_flit(32'h0000_0055, a);
        in_valid = 1'b0;
        check("f_valid_latency", out_valid, 1);
        check("f_data", out_data, 40'h11_2233_4455);
        check("f_type", out_ifmapb_filter, 1);
        check("f_row", out_filter_row, 2);
        idle(2);

        // Ifmap packet with row 7 passes unchecked.
        hdr = 32'h7000_0000;
        expect_pkt(hdr[31], hdr[30:28], 40'hDE_ADBE_EFAB);
        send_flit(hdr, a);
        send_flit(32'hDEAD_BEEF, a);
        send_flit(32'h0000_00AB, a);
        in_valid = 1'b0;
        check("i_valid", out_valid, 1);
        check("i_data", out_data, 40'hDE_ADBE_EFAB);
        check("i_type", out_ifmapb_filter, 0);
        check("i_row", out_filter_row, 7);
        check("i_no_err", err_pulse, 0);
        idle(2);

        // Filter packet with row 6 is dropped.
        hdr = 32'hE000_0000;
        expect_pkt(hdr[31], hdr[30:28], 40'h0);
        send_flit(hdr, a);
        send_flit(32'h0102_0304, a);
        send_flit(32'h0000_0005, a);
        in_valid = 1'b0;
        check("d_err_pulse", err_pulse, 1);
        check("d_drop_cnt", drop_cnt, 1);
        check("d_no_valid", out_valid, 0);
        idle(1);
        check("d_err_one_cycle", err_pulse, 0);
        check("d_no_valid_later", out_valid, 0);

        // Backpressure: hold the triple for 10 cycles with the next header waiting.
        out_ready = 1'b0;
        p = rand_payload();
        send_pkt(1'b1, 3'd4, p, 0, a);
        check("bp_valid", out_valid, 1);
        expect_pkt(1'b0, 3'd3, 40'hA5_5A0F_F0C3);
        in_flit  = mk_hdr(1'b0, 3'd3);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_in_ready", in_ready, 0);
            check("bp_hold_data", out_data, p);
            check("bp_hold_type", out_ifmapb_filter, 1);
            check("bp_hold_row", out_filter_row, 4);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        hs = cycle;
        check("bp_released_valid", out_valid, 0);
        check("bp_released_in_ready", in_ready, 1);
        send_flit(in_flit, a);
        check("bp_next_hdr_cycle", a, hs + 1);
        for (int k = 0; k < NP; k++) send_flit(mk_pay(40'hA5_5A0F_F0C3, k), h0);
        in_valid = 1'b0;
        idle(2);

        // Back-to-back throughput: one packet every NP+2 cycles.
        send_pkt(1'b1, 3'd5, rand_payload(), 0, h0);
        send_pkt(1'b0, 3'd0, rand_payload(), 0, h1);
        send_pkt(1'b1, 3'd1, rand_payload(), 0, h2);
        check("tput_gap_1", h1 - h0, NP + 2);
        check("tput_gap_2", h2 - h1, NP + 2);
        idle(3);

        // Reset after the first payload flit discards the partial packet.
        send_flit(mk_hdr(1'b1, 3'd3), a);
        send_flit(32'hCAFE_F00D, a);
        do_reset();
        send_pkt(1'b1, 3'd3, 40'h12_3456_789A, 0, a);
        check("rst_mid_valid", out_valid, 1);
        check("rst_mid_data", out_data, 40'h12_3456_789A);
        idle(3);

        // Randomized mix with input gaps and random backpressure.
        ordy_rand = 1'b1;
        for (int i = 0; i < 60; i++) begin
            typ = 1'($urandom_range(0, 1));
            row = 3'($urandom_range(0, 7));
            send_pkt(typ, row, rand_payload(), 2, a);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end

        // Saturation: 300 invalid filter packets.
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 2))
                0:       row = 3'd0;
                1:       row = 3'd6;
                default: row = 3'd7;
            endcase
            send_pkt(1'b1, row, rand_payload(), 0, a);
        end
        ordy_rand = 1'b0;
        out_ready = 1'b1;
        idle(20);
        check("sat_drop_cnt", drop_cnt, 255);
        check("sb_out_queue_empty", exp_q.size(), 0);
        check("sb_err_queue_empty", err_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
